memory_stage_mapped: RTL and testbench

Parametrised successor of the memory stage. Decodes the ALU address into NUM_REGIONS memory regions defined by base, size, writability and a second-port flag. Drives external memory macros and realigns the ALU bypass and control bits with a configurable memory latency. Adds an access fault flag and a valid/ready second read port (VGA/readback side) with arbitration for regions that have no second port.

---
 rtl/mem_map_pkg.sv | 32 +++
 rtl/memory_stage_mapped_region_decoder.sv | 42 ++++
 rtl/memory_stage_mapped.sv | 194 +++++++++++++++++++
 tb/tb_memory_stage_mapped.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared constants and pipeline tag type for the mapped memory stage.
package mem_map_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int ADDR_W_DEF   = 18;
  localparam int LOCAL_AW_DEF = 17;

  // Default memory map: image buffer, sine table (ROM, no port B), work RAM.
  localparam int IMAGE_BASE = 0;
  localparam int IMAGE_SIZE = 90000;
  localparam int SIN_BASE   = 90000;
  localparam int SIN_SIZE   = 300;
  localparam int RAM_BASE   = 90300;
  localparam int RAM_SIZE   = 16384;

  // Wide enough for the maximum of 8 regions.
  localparam int TAG_REGION_W = 3;

  typedef struct packed {
    logic                    valid;
    logic                    wb;
    logic                    rd;
    logic                    fault;
    logic [TAG_REGION_W-1:0] region;
  } mem_tag_t;

  // Region index width, never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/memory_stage_mapped_region_decoder.sv
// Combinational address decoder: global address to {hit, region index, local address}.
module region_decoder #(
  parameter int ADDR_W      = 18,
  parameter int LOCAL_AW    = 17,
  parameter int NUM_REGIONS = 3,
  parameter int IDX_W       = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE = '0
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic                hit,
  output logic [IDX_W-1:0]    index,
  output logic [LOCAL_AW-1:0] local_addr
);

  // Scan from the highest index down so the lowest matching region wins.
  always_comb begin
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] size;
    logic [ADDR_W-1:0] diff;
    logic              in_range;
    hit        = 1'b0;
    index      = '0;
    local_addr = '0;
    base       = '0;
    size       = '0;
    diff       = '0;
    in_range   = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      base     = REGION_BASE[i*ADDR_W +: ADDR_W];
      size     = REGION_SIZE[i*ADDR_W +: ADDR_W];
      // One extra bit so base+size cannot wrap at the top of the map.
      in_range = ({1'b0, addr} >= {1'b0, base}) &&
                 ({1'b0, addr} <  ({1'b0, base} + {1'b0, size}));
      diff       = addr - base;
      hit        = hit | in_range;
      index      = in_range ? IDX_W'(i) : index;
      local_addr = in_range ? diff[LOCAL_AW-1:0] : local_addr;
    end
  end

endmodule

// File: rtl/memory_stage_mapped.sv
// Memory stage: decodes port A loads/stores and a port B read stream onto
// per-region memory macros, and realigns results with the macro read latency.
module memory_stage_mapped
  import mem_map_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int LOCAL_AW    = LOCAL_AW_DEF,
  parameter int NUM_REGIONS = 3,
  parameter int RD_LATENCY  = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {ADDR_W'(RAM_BASE), ADDR_W'(SIN_BASE), ADDR_W'(IMAGE_BASE)},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_SIZE =
    {ADDR_W'(RAM_SIZE), ADDR_W'(SIN_SIZE), ADDR_W'(IMAGE_SIZE)},
  parameter logic [NUM_REGIONS-1:0] REGION_WRITABLE = 3'b100,
  parameter logic [NUM_REGIONS-1:0] REGION_HAS_B    = 3'b101
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            valid_in,
  input  logic                            writeback_enable,
  input  logic                            read_enable,
  input  logic                            write_enable,
  input  logic [DATA_W-1:0]               alu_result,
  input  logic [DATA_W-1:0]               write_data_a,
  output logic                            valid_out,
  output logic                            writeback_enable_out,
  output logic                            read_enable_out,
  output logic [DATA_W-1:0]               result,
  output logic                            fault_a,
  input  logic                            b_req,
  input  logic [ADDR_W-1:0]               b_addr,
  output logic                            b_ready,
  output logic                            b_valid,
  output logic [DATA_W-1:0]               b_data,
  output logic                            b_fault,
  output logic [NUM_REGIONS*LOCAL_AW-1:0] mem_addr_a,
  output logic [NUM_REGIONS-1:0]          mem_rden_a,
  output logic [NUM_REGIONS-1:0]          mem_wren_a,
  output logic [DATA_W-1:0]               mem_wdata_a,
  input  logic [NUM_REGIONS*DATA_W-1:0]   mem_q_a,
  output logic [NUM_REGIONS*LOCAL_AW-1:0] mem_addr_b,
  output logic [NUM_REGIONS-1:0]          mem_rden_b,
  input  logic [NUM_REGIONS*DATA_W-1:0]   mem_q_b
);

  localparam int IDX_W = idx_width(NUM_REGIONS);

  logic                   a_hit;
  logic [IDX_W-1:0]       a_idx;
  logic [LOCAL_AW-1:0]    a_local;
  logic                   b_hit;
  logic [IDX_W-1:0]       b_idx;
  logic [LOCAL_AW-1:0]    b_local;
  logic [NUM_REGIONS-1:0] a_sel;
  logic [NUM_REGIONS-1:0] b_sel;
  logic                   a_op;
  logic                   a_wr;
  logic                   a_rd;
  logic                   a_fault;
  logic                   b_has_port;
  logic                   b_conflict;
  logic                   b_accept;
  mem_tag_t               a_next;
  mem_tag_t               b_next;
  mem_tag_t               a_tag [RD_LATENCY];
  mem_tag_t               b_tag [RD_LATENCY];
  logic [DATA_W-1:0]      a_val [RD_LATENCY];
  mem_tag_t               a_last;
  mem_tag_t               b_last;
  logic [DATA_W-1:0]      a_q;
  logic [DATA_W-1:0]      b_q;
  logic                   b_tag_unused;

  region_decoder #(
    .ADDR_W(ADDR_W), .LOCAL_AW(LOCAL_AW), .NUM_REGIONS(NUM_REGIONS), .IDX_W(IDX_W),
    .REGION_BASE(REGION_BASE), .REGION_SIZE(REGION_SIZE)
  ) u_dec_a (
    .addr(alu_result[ADDR_W-1:0]), .hit(a_hit), .index(a_idx), .local_addr(a_local)
  );

  region_decoder #(
    .ADDR_W(ADDR_W), .LOCAL_AW(LOCAL_AW), .NUM_REGIONS(NUM_REGIONS), .IDX_W(IDX_W),
    .REGION_BASE(REGION_BASE), .REGION_SIZE(REGION_SIZE)
  ) u_dec_b (
    .addr(b_addr), .hit(b_hit), .index(b_idx), .local_addr(b_local)
  );

  // Store wins when both read and write are requested.
  assign a_op = valid_in & (read_enable | write_enable);
  assign a_wr = a_op & write_enable;
  assign a_rd = a_op & ~write_enable;

  // One-hot region selects for both ports.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      a_sel[i] = a_hit & (a_idx == IDX_W'(i));
      b_sel[i] = b_hit & (b_idx == IDX_W'(i));
    end
  end

  assign a_fault    = a_op & (~a_hit | (a_wr & ~(|(a_sel & REGION_WRITABLE))));
  assign b_has_port = |(b_sel & REGION_HAS_B);
  // A region without its own port B borrows port A, so it yields to port A.
  assign b_conflict = a_op & (|(a_sel & b_sel));
  assign b_accept   = ~rst & b_req & (~b_hit | b_has_port | ~b_conflict);
  assign b_ready    = b_accept;

  assign mem_wdata_a = write_data_a;

  // Per-region macro controls; an accepted port B read on a no-B region takes port A.
  always_comb begin
    mem_addr_a = '0;
    mem_addr_b = '0;
    mem_rden_a = '0;
    mem_wren_a = '0;
    mem_rden_b = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      mem_wren_a[i] = ~rst & a_wr & a_sel[i] & REGION_WRITABLE[i];
      mem_rden_a[i] = (~rst & a_rd & a_sel[i]) |
                      (b_accept & b_sel[i] & ~REGION_HAS_B[i]);
      mem_addr_a[i*LOCAL_AW +: LOCAL_AW] =
        (b_accept & b_sel[i] & ~REGION_HAS_B[i]) ? b_local : a_local;
      mem_rden_b[i] = b_accept & b_sel[i] & REGION_HAS_B[i];
      mem_addr_b[i*LOCAL_AW +: LOCAL_AW] = b_local;
    end
  end

  // Tags entering the pipelines; idle cycles shift in zeros so outputs rest at 0.
  always_comb begin
    a_next        = '0;
    a_next.valid  = valid_in;
    a_next.wb     = valid_in & writeback_enable;
    a_next.rd     = a_rd;
    a_next.fault  = a_fault;
    a_next.region = TAG_REGION_W'(a_idx);
    b_next        = '0;
    b_next.valid  = b_accept;
    b_next.wb     = 1'b0;
    b_next.rd     = b_accept & b_hit;
    b_next.fault  = b_accept & ~b_hit;
    b_next.region = TAG_REGION_W'(b_idx);
  end

  // Tag shift registers matching the macro read latency; reset drops in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        a_tag[k] <= '0;
        b_tag[k] <= '0;
        a_val[k] <= '0;
      end
    end else begin
      a_tag[0] <= a_next;
      b_tag[0] <= b_next;
      a_val[0] <= valid_in ? alu_result : '0;
      for (int k = 1; k < RD_LATENCY; k++) begin
        a_tag[k] <= a_tag[k-1];
        b_tag[k] <= b_tag[k-1];
        a_val[k] <= a_val[k-1];
      end
    end
  end

  assign a_last       = a_tag[RD_LATENCY-1];
  assign b_last       = b_tag[RD_LATENCY-1];
  assign b_tag_unused = b_last.wb;

  assign valid_out            = a_last.valid;
  assign writeback_enable_out = a_last.wb;
  assign read_enable_out      = a_last.rd;
  assign fault_a              = a_last.fault;
  assign b_valid              = b_last.valid;
  assign b_fault              = b_last.fault;

  // Pick returning macro data for the tagged regions.
  always_comb begin
    a_q = '0;
    b_q = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      a_q = (a_last.region == TAG_REGION_W'(i)) ? mem_q_a[i*DATA_W +: DATA_W] : a_q;
      b_q = (b_last.region == TAG_REGION_W'(i)) ?
            (REGION_HAS_B[i] ? mem_q_b[i*DATA_W +: DATA_W] : mem_q_a[i*DATA_W +: DATA_W]) :
            b_q;
    end
  end

  assign result = ~a_last.rd   ? a_val[RD_LATENCY-1] :
                  a_last.fault ? '0 : a_q;
  assign b_data = b_last.rd ? b_q : '0;

endmodule

// File: tb/tb_memory_stage_mapped.sv
// Randomized self-checking bench with behavioural memory macros and a
// global-address reference memory.
module tb_memory_stage_mapped;

  localparam int DW  = 24;
  localparam int AW  = 18;
  localparam int LAW = 17;
  localparam int NR  = 3;

  int base_t [3] = '{0, 90000, 90300};
  int size_t [3] = '{90000, 300, 16384};
  bit wr_t   [3] = '{1'b0, 1'b0, 1'b1};
  bit hasb_t [3] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0, writeback_enable = 1'b0, read_enable = 1'b0, write_enable = 1'b0;
  logic [DW-1:0] alu_result = '0, write_data_a = '0;
  logic valid_out, writeback_enable_out, read_enable_out, fault_a;
  logic [DW-1:0] result;
  logic b_req = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic b_ready, b_valid, b_fault;
  logic [DW-1:0] b_data;
  logic [NR*LAW-1:0] mem_addr_a, mem_addr_b;
  logic [NR-1:0] mem_rden_a, mem_wren_a, mem_rden_b;
  logic [DW-1:0] mem_wdata_a;
  logic [NR*DW-1:0] mem_q_a, mem_q_b;

  memory_stage_mapped dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .writeback_enable(writeback_enable),
    .read_enable(read_enable), .write_enable(write_enable), .alu_result(alu_result),
    .write_data_a(write_data_a), .valid_out(valid_out),
    .writeback_enable_out(writeback_enable_out), .read_enable_out(read_enable_out),
    .result(result), .fault_a(fault_a), .b_req(b_req), .b_addr(b_addr),
    .b_ready(b_ready), .b_valid(b_valid), .b_data(b_data), .b_fault(b_fault),
    .mem_addr_a(mem_addr_a), .mem_rden_a(mem_rden_a), .mem_wren_a(mem_wren_a),
    .mem_wdata_a(mem_wdata_a), .mem_q_a(mem_q_a), .mem_addr_b(mem_addr_b),
    .mem_rden_b(mem_rden_b), .mem_q_b(mem_q_b)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory macros (2-cycle read) ----------------
  logic [DW-1:0]  mem_m [3][131072];
  logic [DW-1:0]  ref_mem [131072];
  logic [LAW-1:0] areg_a [3];
  logic [LAW-1:0] areg_b [3];
  logic [DW-1:0]  q_a [3];
  logic [DW-1:0]  q_b [3];

  assign mem_q_a = {q_a[2], q_a[1], q_a[0]};
  assign mem_q_b = {q_b[2], q_b[1], q_b[0]};

  function automatic logic [DW-1:0] pat(input int g);
    logic [31:0] t;
    t = (32'(g) * 32'd40503) ^ 32'h005A5A5A;
    return t[DW-1:0];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < 3; r++) begin
      areg_a[r] <= mem_addr_a[r*LAW +: LAW];
      areg_b[r] <= mem_addr_b[r*LAW +: LAW];
      q_a[r]    <= mem_m[r][areg_a[r]];
      q_b[r]    <= mem_m[r][areg_b[r]];
      if (mem_wren_a[r] === 1'b1) mem_m[r][mem_addr_a[r*LAW +: LAW]] <= mem_wdata_a;
    end
  end

  initial begin
    for (int r = 0; r < 3; r++) begin
      areg_a[r] = '0;
      areg_b[r] = '0;
      for (int l = 0; l < 131072; l++) mem_m[r][l] = (l < size_t[r]) ? pat(base_t[r] + l) : '0;
    end
    for (int g = 0; g < 131072; g++) ref_mem[g] = pat(g);
  end

  // ---------------- reference model and checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit m_b_acc;
  bit e_valid [8], e_wb [8], e_rd [8], e_fault [8], eb_valid [8], eb_fault [8];
  logic [DW-1:0] e_res [8], eb_data [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int region_of(input int a);
    for (int i = 0; i < 3; i++)
      if (a >= base_t[i] && a < base_t[i] + size_t[i]) return i;
    return -1;
  endfunction

  function automatic logic [AW-1:0] gen_addr();
    int r = $urandom_range(0, 2);
    int v;
    case ($urandom_range(0, 7))
      0:       v = base_t[r];
      1:       v = base_t[r] + size_t[r] - 1;
      2:       v = base_t[r] + size_t[r];
      3, 4, 5: v = base_t[r] + int'($urandom % size_t[r]);
      6:       v = base_t[r] - 1;
      default: v = int'($urandom);
    endcase
    return AW'(v);
  endfunction

  task automatic clear_slot(input int s);
    e_valid[s] = 0; e_wb[s] = 0; e_rd[s] = 0; e_fault[s] = 0; e_res[s] = '0;
    eb_valid[s] = 0; eb_fault[s] = 0; eb_data[s] = '0;
  endtask

  // One clock cycle: check outputs due now, drive inputs, check macro controls, predict.
  task automatic do_cycle(input bit r, input bit v, input bit wb, input bit rd, input bit wr,
                          input logic [DW-1:0] alu, input logic [DW-1:0] wd,
                          input bit breq, input logic [AW-1:0] baddr);
    int s  = cyc % 8;
    int ns = (cyc + 2) % 8;
    int aa = int'(alu[AW-1:0]);
    int ba = int'(baddr);
    int ra = region_of(aa);
    int rb = region_of(ba);
    bit a_op, a_wr, a_rd, flt, acc;
    logic [NR-1:0] x_wren, x_rdena, x_rdenb;
    logic [DW-1:0] x_res;
    chk("valid_out", valid_out, e_valid[s]);
    chk("wb_out", writeback_enable_out, e_wb[s]);
    chk("rd_out", read_enable_out, e_rd[s]);
    chk("fault_a", fault_a, e_fault[s]);
    chk("result", result, e_res[s]);
    chk("b_valid", b_valid, eb_valid[s]);
    chk("b_fault", b_fault, eb_fault[s]);
    chk("b_data", b_data, eb_data[s]);

    rst = r; valid_in = v; writeback_enable = wb; read_enable = rd; write_enable = wr;
    alu_result = alu; write_data_a = wd; b_req = breq; b_addr = baddr;
    #1;

    a_op = !r && v && (rd || wr);
    a_wr = a_op && wr;
    a_rd = a_op && !wr;
    flt  = a_op && (ra < 0 || (a_wr && !wr_t[ra]));
    acc  = !r && breq && (rb < 0 || hasb_t[rb] || !(a_op && ra == rb));
    x_wren = '0; x_rdena = '0; x_rdenb = '0;
    if (a_wr && ra >= 0 && wr_t[ra]) x_wren[ra] = 1'b1;
    if (a_rd && ra >= 0) x_rdena[ra] = 1'b1;
    if (acc && rb >= 0 && !hasb_t[rb]) x_rdena[rb] = 1'b1;
    if (acc && rb >= 0 && hasb_t[rb]) x_rdenb[rb] = 1'b1;

    chk("b_ready", b_ready, acc);
    chk("wren_a", mem_wren_a, x_wren);
    chk("rden_a", mem_rden_a, x_rdena);
    chk("rden_b", mem_rden_b, x_rdenb);
    if (a_op && ra >= 0) chk("addr_a", mem_addr_a[ra*LAW +: LAW], aa - base_t[ra]);
    if (x_wren != '0) chk("wdata_a", mem_wdata_a, wd);
    if (acc && rb >= 0 && hasb_t[rb]) chk("addr_b", mem_addr_b[rb*LAW +: LAW], ba - base_t[rb]);
    if (acc && rb >= 0 && !hasb_t[rb]) chk("addr_a_for_b", mem_addr_a[rb*LAW +: LAW], ba - base_t[rb]);

    clear_slot(ns);
    if (!r) begin
      if (!v) x_res = '0;
      else if (a_rd) x_res = flt ? '0 : ref_mem[aa];
      else x_res = alu;
      e_valid[ns] = v; e_wb[ns] = v && wb; e_rd[ns] = a_rd; e_fault[ns] = flt; e_res[ns] = x_res;
      if (x_wren != '0) ref_mem[aa] = wd;
      eb_valid[ns] = acc;
      eb_fault[ns] = acc && rb < 0;
      eb_data[ns]  = (acc && rb >= 0) ? ref_mem[ba] : '0;
    end else begin
      clear_slot((cyc + 1) % 8);
    end
    m_b_acc = acc;
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, '0, '0, 0, '0);
  endtask

  bit            b_pend = 0;
  logic [AW-1:0] b_pa   = '0;

  initial begin
    for (int s = 0; s < 8; s++) clear_slot(s);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Directed scenarios
    do_cycle(0, 1, 1, 1, 0, 24'd100, '0, 0, '0);
    do_cycle(0, 1, 0, 0, 1, 24'd90305, 24'hABCDEF, 0, '0);
    idle(1);
    do_cycle(0, 1, 1, 1, 0, 24'd90305, '0, 0, '0);
    do_cycle(0, 1, 0, 0, 1, 24'd50, 24'h111111, 0, '0);
    idle(2);
    for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 1, 0, 24'd90010, '0, 1, 18'd90020);
    do_cycle(0, 0, 0, 0, 0, '0, '0, 1, 18'd90020);
    do_cycle(0, 0, 0, 0, 0, '0, '0, 1, 18'h3FFFF);
    do_cycle(0, 1, 1, 0, 0, 24'h123456, '0, 0, '0);
    do_cycle(0, 1, 1, 1, 1, 24'd90400, 24'h0F0F0F, 1, 18'd90400);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bit v = ($urandom % 4) != 0;
      bit rd = 0, wr = 0;
      logic [DW-1:0] alu;
      case ($urandom_range(0, 4))
        0:       begin rd = 0; wr = 0; end
        1, 2:    begin rd = 1; wr = 0; end
        3:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      if (!b_pend && ($urandom % 3) != 0) begin
        b_pend = 1;
        b_pa = gen_addr();
      end
      alu = {6'($urandom), gen_addr()};
      if (b_pend && ($urandom % 3) == 0) alu[AW-1:0] = b_pa;
      do_cycle(0, v, 1'($urandom), rd, wr, alu, 24'($urandom), b_pend,
               b_pend ? b_pa : 18'($urandom));
      if (m_b_acc) b_pend = 0;
    end
    if (b_pend) do_cycle(0, 0, 0, 0, 0, '0, '0, 1, b_pa);
    idle(3);

    // Reset one cycle after a read issue drops it
    do_cycle(0, 1, 1, 1, 0, 24'd100, '0, 1, 18'd200);
    do_cycle(1, 1, 1, 1, 0, 24'd90310, '0, 1, 18'd90020);
    idle(4);
    do_cycle(0, 1, 0, 1, 0, 24'd90001, '0, 0, '0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
